// File: rtl/isqrt_param.sv
// isqrt_param: sequential restoring integer square root, one root bit per clock.
// sol = floor(sqrt(a)) for a W-bit radicand, start/valid handshake, busy flag.
// Optional remainder output port `rem` is built only when ISQRT_REM_EN is defined.
module isqrt_param #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [W-1:0]   a,
    input  logic           start,
    output logic [W/2-1:0] sol,
`ifdef ISQRT_REM_EN
    output logic [W/2:0]   rem,
`endif
    output logic           valid,
    output logic           busy
);
    localparam int R  = W / 2;
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  x_q, x_d;
    logic [R-1:0]  q_q, q_d;
    logic [R+1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [R-1:0]  sol_q, sol_d;
`ifdef ISQRT_REM_EN
    logic [R:0]    rem_q, rem_d;
`endif

    logic [R+1:0]  p_sh;
    logic [R+1:0]  t_val;
    logic [R+1:0]  p_nx;
    logic [R-1:0]  q_nx;
    logic          ge;
    logic          accept;

    // One restoring step: bring down two radicand bits, trial-subtract 4Q+1.
    always_comb begin
        p_sh  = (p_q << 2) | (R+2)'(x_q[W-1:W-2]);
        t_val = {q_q, 2'b01};
        ge    = (p_sh >= t_val);
        p_nx  = ge ? (p_sh - t_val) : p_sh;
        q_nx  = {q_q[R-2:0], ge};
    end

    // Next-state and datapath update; a new request is accepted in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        q_d     = q_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        sol_d   = sol_q;
`ifdef ISQRT_REM_EN
        rem_d   = rem_q;
`endif
        accept  = start && (state_q != CALC);

        case (state_q)
            IDLE: begin
                if (start) state_d = CALC;
            end
            CALC: begin
                x_d   = x_q << 2;
                p_d   = p_nx;
                q_d   = q_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    sol_d   = q_nx;
`ifdef ISQRT_REM_EN
                    rem_d   = p_nx[R:0];
`endif
                end
            end
            DONE: begin
                state_d = start ? CALC : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            x_d   = a;
            q_d   = '0;
            p_d   = '0;
            cnt_d = CW'(R - 1);
        end
    end

    // State and datapath registers; clr discards everything including results.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            x_q     <= '0;
            q_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            sol_q   <= '0;
`ifdef ISQRT_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            q_q     <= q_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            sol_q   <= sol_d;
`ifdef ISQRT_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign sol   = sol_q;
`ifdef ISQRT_REM_EN
    assign rem   = rem_q;
`endif
    assign valid = (state_q == DONE);
    assign busy  = (state_q == CALC);

endmodule

// File: tb/tb_isqrt_param.sv
// Testbench for isqrt_param: W=8 and W=16 instances, queue scoreboard of
// expected results (value and arrival cycle). Remainder checks are compiled
// in when ISQRT_REM_EN is defined.
`timescale 1ns/1ps
module tb_isqrt_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       clr8, start8, valid8, busy8;
    logic [7:0] a8;
    logic [3:0] sol8;
    logic       clr16, start16, valid16, busy16;
    logic [15:0] a16;
    logic [7:0]  sol16;
`ifdef ISQRT_REM_EN
    logic [4:0]  rem8;
    logic [8:0]  rem16;
`endif

    isqrt_param #(.W(8)) u8 (
        .clk(clk), .clr(clr8), .a(a8), .start(start8), .sol(sol8),
`ifdef ISQRT_REM_EN
        .rem(rem8),
`endif
        .valid(valid8), .busy(busy8)
    );

    isqrt_param #(.W(16)) u16 (
        .clk(clk), .clr(clr16), .a(a16), .start(start16), .sol(sol16),
`ifdef ISQRT_REM_EN
        .rem(rem16),
`endif
        .valid(valid16), .busy(busy16)
    );

    typedef struct {
        int sol;
        int rem;
        int due;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int isqrt_ref(input int v);
        int s = 0;
        while ((s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    function automatic exp_t make_exp(input int v, input int lat);
        exp_t e;
        e.sol = isqrt_ref(v);
        e.rem = v - e.sol * e.sol;
        e.due = cyc + 1 + lat;
        return e;
    endfunction

    // Caller guarantees the DUT is in IDLE or DONE so the request is accepted.
    task automatic issue8(input int v);
        a8 = 8'(v);
        q8.push_back(make_exp(v, 4));
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue16(input int v);
        a16 = 16'(v);
        q16.push_back(make_exp(v, 8));
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait_valid8();
        int k = 0;
        while (!valid8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!valid8) check("w8_timeout", 0, 1);
    endtask

    task automatic wait_valid16();
        int k = 0;
        while (!valid16 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!valid16) check("w16_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (valid8) begin
            if (q8.size() == 0) check("w8_spurious_valid", 1, 0);
            else begin
                e8 = q8.pop_front();
                check("w8_sol", int'(sol8), e8.sol);
`ifdef ISQRT_REM_EN
                check("w8_rem", int'(rem8), e8.rem);
`endif
                check("w8_latency", cyc, e8.due);
            end
        end
    end

    always @(negedge clk) begin
        if (valid16) begin
            if (q16.size() == 0) check("w16_spurious_valid", 1, 0);
            else begin
                e16 = q16.pop_front();
                check("w16_sol", int'(sol16), e16.sol);
`ifdef ISQRT_REM_EN
                check("w16_rem", int'(rem16), e16.rem);
`endif
                check("w16_latency", cyc, e16.due);
            end
        end
    end

    initial begin
        int bc;
        int k;
        clr8 = 1'b1; start8 = 1'b0; a8 = '0;
        clr16 = 1'b1; start16 = 1'b0; a16 = '0;
        repeat (3) @(negedge clk);
        check("rst_sol8", int'(sol8), 0);
        check("rst_valid8", int'(valid8), 0);
        check("rst_busy8", int'(busy8), 0);
        check("rst_sol16", int'(sol16), 0);
        check("rst_valid16", int'(valid16), 0);
        check("rst_busy16", int'(busy16), 0);
`ifdef ISQRT_REM_EN
        check("rst_rem8", int'(rem8), 0);
        check("rst_rem16", int'(rem16), 0);
`endif
        clr8 = 1'b0;
        clr16 = 1'b0;
        @(negedge clk);

        // W=8, a=0: busy for exactly four cycles, then one valid pulse.
        issue8(0);
        bc = int'(busy8);
        k = 0;
        while (!valid8 && k < 40) begin
            @(negedge clk);
            k++;
            bc += int'(busy8);
        end
        check("w8_zero_busy_cycles", bc, 4);
        @(negedge clk);
        check("w8_valid_one_cycle", int'(valid8), 0);
        check("w8_idle_not_busy", int'(busy8), 0);

        // W=8 full sweep, each request issued back-to-back in DONE.
        for (int v = 0; v < 256; v++) begin
            issue8(v);
            wait_valid8();
        end
        @(negedge clk);

        // W=16 maximum radicand and largest exact square.
        issue16(65535);
        wait_valid16();
        issue16(65025);
        wait_valid16();
        @(negedge clk);

        // Start mid-CALC is ignored; previous result holds during computation.
        issue16(100);
        @(negedge clk);
        check("w16_sol_held", int'(sol16), 255);
        a16 = 16'd9;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        wait_valid16();

        // Start held through DONE: accepted back-to-back, result due 9 cycles later.
        a16 = 16'd9;
        q16.push_back(make_exp(9, 8));
        start16 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start16 = 1'b0;
        wait_valid16();
        @(negedge clk);

        // clr on the fourth iteration edge discards the operation.
        issue16(50000);
        repeat (3) @(negedge clk);
        check("w16_busy_before_clr", int'(busy16), 1);
        clr16 = 1'b1;
        q16.delete();
        @(negedge clk);
        clr16 = 1'b0;
        check("clr_busy16", int'(busy16), 0);
        check("clr_valid16", int'(valid16), 0);
        check("clr_sol16", int'(sol16), 0);
`ifdef ISQRT_REM_EN
        check("clr_rem16", int'(rem16), 0);
`endif
        repeat (15) @(negedge clk);
        check("clr_stays_idle", int'(busy16), 0);
        issue16(50000);
        wait_valid16();
        @(negedge clk);

        check("q8_drained", q8.size(), 0);
        check("q16_drained", q16.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/isqrt_param.md
# isqrt_param

Parametrised, sequential integer square root unit. Computes `sol = floor(sqrt(a))` for a W-bit unsigned radicand using the restoring digit-by-digit method, one result bit per clock, with a start/valid handshake and a busy flag. It is the width-generic successor to the fixed 8-bit square root block, shares the same control-plus-datapath structure, and adds back-to-back issue and an optional remainder output.

## Interface
- `W`, default 16: radicand width in bits; even, ≥ 4. Root width R = W/2.
- `clk`  in  1  clock; all state changes on its rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `a`  in  W  unsigned radicand; sampled only on the edge that accepts `start`.
- `start`  in  1  request; accepted in IDLE or DONE, ignored in CALC.
- `sol`  out  R  root result register.
- `rem`  out  R+1  remainder `a - sol*sol`; present only with `ISQRT_REM_EN`.
- `valid`  out  1  one-cycle pulse: `sol`/`rem` are newly updated.
- `busy`  out  1  high while iterating.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: `start`=1 → load and go to CALC; otherwise stay.
  - CALC: one iteration per cycle. Iteration counter counts R-1 down to 0. On the edge that performs the iteration with counter = 0 → DONE.
  - DONE: `start`=1 → load and go to CALC (back-to-back issue); otherwise go to IDLE.
- Load:
  - Latch `a` into shift register X.
  - Clear working root Q (R bits) and working remainder P (R+2 bits).
  - Counter = R-1.
- Iteration:
  - P' = (P << 2) | X[W-1:W-2]; X <<= 2.
  - T = (Q << 2) | 1, computed at R+2 bits.
  - If P' ≥ T: P = P' - T and Q = (Q << 1) | 1.
  - Else: P = P' and Q = Q << 1.
- Completion edge (CALC → DONE): copy Q to `sol` and P[R:0] to `rem`. These output registers change at no other time, so they hold the previous result throughout a new computation.
- Width rule: the final remainder is ≤ 2·sol, so it fits in R+1 bits. P carries 1 guard bit to hold intermediate values. No overflow is possible for any input.
- `start` in CALC is ignored; no queueing or error flag.
- `a` changing outside the accept edge has no effect.
- `clr`=1 on any edge, including mid-CALC:
  - State goes to IDLE.
  - `sol`, `rem`, Q, P, X and the counter are zeroed.
  - `valid`=0 and `busy`=0.
  - The operation in progress is discarded.
  - `clr` takes priority over `start` on the same edge.

## Timing
- Reset values: `sol`=0, `rem`=0, `valid`=0, `busy`=0, state IDLE.
- `valid` is high exactly when state = DONE. `busy` is high exactly when state = CALC. Both are decoded from registered state, with no combinational path from inputs.
- Latency: `start` sampled at edge E0 → iterations at E1..ER → `sol`/`rem` updated at ER, with `valid`=1 during the cycle after ER.
  - W=16: 8 iteration cycles. `valid` is high in the 9th cycle counted from the E0 cycle.
- Throughput: with `start` held high in DONE, one result every R+1 cycles.
- On a back-to-back accept in DONE, `valid` is still high for that DONE cycle. `busy` rises on the next cycle.

## Configuration
- `ISQRT_REM_EN` defined:
  - Port `rem` [R:0] exists.
  - Completion copies P[R:0] into the `rem` register.
- `ISQRT_REM_EN` undefined:
  - Port `rem` and its output register are omitted.
  - P is still kept internally, since the comparison needs it.
  - All other behaviour and timing are identical.

## Test plan
- W=8, `a`=0, one `start` pulse → `valid` pulses 4 cycles after the accept edge; `sol`=0, `rem`=0; `busy` high for exactly 4 cycles.
- W=8, sweep `a`=0..255 → every result matches floor(sqrt); spot checks `a`=255 → `sol`=15, `rem`=30 and `a`=200 → `sol`=14, `rem`=4.
- W=16, `a`=65535 → `sol`=255, `rem`=510 at cycle 8; then `a`=65536-1-510 (=65025) → `sol`=255, `rem`=0.
- W=16: `start` with `a`=100, then `start` pulsed again with `a`=9 mid-CALC → the second start is ignored and the result is `sol`=10, `rem`=0. `start` held through DONE with `a`=9 → the next result is `sol`=3, `rem`=0, 9 cycles after the previous DONE.
- W=16: `clr` asserted at iteration 4 of `a`=50000 → next cycle: state IDLE, `sol`=0, `rem`=0, `busy`=0, and no `valid` pulse ever appears. Restart with `a`=50000 → `sol`=223, `rem`=271.
- Build without `ISQRT_REM_EN`, W=8, `a`=255 → `sol`=15 with identical `valid` timing; the elaborated netlist has no `rem` port.
